// File: rtl/log2_arbiter.sv
// log2_arbiter: shares one log2 unit among N requesters.
// Round-robin grant in IDLE, one operation in flight, illegal operands
// (negative, zero/denormal, inf/NaN) are answered directly with resp_err=1
// and never reach the unit.
module log2_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [32*N-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic [31:0]       log2_a,
    input  logic [7:0]        log2_int_in,
    input  logic [31:0]       log2_frac_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [7:0]        resp_int,
    output logic [31:0]       resp_frac,
    output logic              resp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wrap point for the round-robin scan, sized to the widened candidate index.
    localparam logic [IDW:0] NW       = (IDW + 1)'(N);
    localparam logic [IDW-1:0] LASTID = IDW'(N - 1);
    localparam logic [3:0]  LATV      = 4'(LAT);

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     log2_a_q, log2_a_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [7:0]      resp_int_q, resp_int_d;
    logic [31:0]     resp_frac_q, resp_frac_d;
    logic            resp_err_q, resp_err_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand_wide;
    logic [IDW-1:0]  cand;
    logic [31:0]     operand;
    logic            operand_illegal;

    // Round-robin scan starting just after the last winner; first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_wide   = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand_wide = {1'b0, last_grant_q} + (IDW + 1)'(k);
            if (cand_wide >= NW) begin
                cand_wide = cand_wide - NW;
            end
            cand = cand_wide[IDW-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pick the winner's operand and screen it for sign, zero/denormal and inf/NaN.
    always_comb begin
        operand = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                operand = req_data[32*i +: 32];
            end
        end
        operand_illegal = operand[31] ||
                          (operand[30:23] == 8'h00) ||
                          (operand[30:23] == 8'hFF);
    end

    // One-hot accept to the winner, only while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic: issue in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        log2_a_d     = log2_a_q;
        resp_id_d    = resp_id_q;
        resp_int_d   = resp_int_q;
        resp_frac_d  = resp_frac_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    resp_id_d    = grant_idx;
                    last_grant_d = grant_idx;
                    if (operand_illegal) begin
                        resp_err_d  = 1'b1;
                        resp_int_d  = 8'd0;
                        resp_frac_d = 32'd0;
                        state_d     = RESP;
                    end else begin
                        log2_a_d = operand;
                        cnt_d    = LATV;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    resp_int_d  = log2_int_in;
                    resp_frac_d = log2_frac_in;
                    resp_err_d  = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LASTID;
            cnt_q        <= 4'd0;
            log2_a_q     <= 32'd0;
            resp_id_q    <= '0;
            resp_int_q   <= 8'd0;
            resp_frac_q  <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            log2_a_q     <= log2_a_d;
            resp_id_q    <= resp_id_d;
            resp_int_q   <= resp_int_d;
            resp_frac_q  <= resp_frac_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign log2_a     = log2_a_q;
    assign resp_valid = (state_q == RESP);
    assign resp_id    = resp_id_q;
    assign resp_int   = resp_int_q;
    assign resp_frac  = resp_frac_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/log2_arbiter.md
Name:
log2_arbiter

Overview:
- Shares one `log2` unit among N requesters.
- The unit takes an IEEE-754 single-precision operand `a` and returns `log2_a_int_part[7:0]` and `log2_a_frac_part[31:0]`.
- Round-robin arbitration, one operation in flight, valid/ready handshakes on both the request and response sides.
- Screens illegal operands before they reach the unit.
- Sits between the feature-extraction requesters and the shared ALU `log2` instance.

Parameters:
- N, 4, number of requesters.
- IDW, 2, requester ID width; must equal ceil(log2(N)).
- LAT, 1, cycles from `log2_a` stable to result capture. Range 1..15, which allows a registered or pipelined `log2`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N  per-requester request valid.
- req_data  input  32*N  per-requester float operand; requester i occupies bits [32i+31:32i].
- req_ready  output  N  one-hot grant/accept; high only in IDLE and only for the winner.
- log2_a  output  32  operand register driving `log2.a`.
- log2_int_in  input  8  from `log2.log2_a_int_part`.
- log2_frac_in  input  32  from `log2.log2_a_frac_part`.
- resp_valid  output  1  response available.
- resp_ready  input  1  response consumer accepts.
- resp_id  output  IDW  requester index of this response.
- resp_int  output  8  captured integer part.
- resp_frac  output  32  captured fraction part.
- resp_err  output  1  operand was illegal; result fields forced to 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values (async): state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_int=0, resp_frac=0, resp_err=0, log2_a=0, cnt=0, last_grant=N-1. With last_grant=N-1, requester 0 has first priority.
- States: IDLE, WAIT, RESP.
- Arbitration (combinational in IDLE):
  - Scan requesters starting at (last_grant+1) mod N; the first with req_valid=1 wins.
  - req_ready[winner]=1; all other bits 0. req_ready=0 in WAIT and RESP.
  - Handshake = req_valid[i] & req_ready[i] in cycle T.
- Operand screening at the handshake (operand `x`, exponent e=x[30:23]):
  - Illegal if x[31]=1, or e=0 (zero/denormal), or e=8'hFF (inf/NaN).
- On handshake at T:
  - Always: resp_id<=winner, last_grant<=winner.
  - Legal operand: log2_a<=x, cnt<=LAT, next state WAIT.
  - Illegal operand: log2_a unchanged, resp_err<=1, resp_int<=0, resp_frac<=0, next state RESP. resp_valid=1 at T+1.
- WAIT:
  - If cnt==1: capture resp_int<=log2_int_in, resp_frac<=log2_frac_in, resp_err<=0, go to RESP.
  - Else: cnt<=cnt-1.
  - Legal-operand latency: resp_valid=1 at cycle T+1+LAT.
- RESP:
  - resp_valid=1 (registered: resp_valid = state==RESP).
  - All resp_* fields held stable while resp_ready=0, with no limit on stall length.
  - When resp_ready=1: go to IDLE, resp_valid deasserts next cycle.
  - No new grant in the same cycle as response acceptance. The minimum issue interval is LAT+2 cycles for legal operands and 2 cycles for illegal ones.
- log2_a holds its last legal operand after completion; it is never cleared except by reset.
- Requesters may drop or change req_valid and req_data while not granted; the block samples req_data only at the handshake.
- A requester held valid is served within N operations (round-robin fairness).
- Reset asserted in any state, including mid-WAIT or mid-RESP: the operation is discarded, all outputs return to reset values immediately, and nothing is emitted after reset releases.

Test Plan:
- Single request, LAT=1: after reset, req0 sends 32'h40800000 (4.0); log2 model returns int=2, frac=0. Expected: req_ready[0] at T, log2_a=40800000 at T+1, resp_valid at T+2 with id=0, int=8'd2, frac=0, err=0.
- Fairness: req0 and req2 held valid continuously with 3F800000 and 40000000. Expected grant order 0, 2, 0, 2. resp_int alternates 0 and 1; resp_id alternates 0 and 2.
- Illegal operands: BF800000 (-1.0), 00000000, 7F800000 each produce resp_valid one cycle after the handshake with err=1, int=0, frac=0; log2_a remains 40800000 from the prior op.
- Backpressure: operand 41D80000 (27.0), resp_ready held 0 for 5 cycles. Expected: resp_* stable and identical to the model output, req_ready=0 throughout, busy=1. Release: resp_valid drops the next cycle.
- LAT=3: operand 42920000 (73.0). Expected: resp_valid at T+4 with int=8'd6 and frac equal to the model value.
- Reset mid-WAIT (LAT=3): assert rst at T+2. Expected: outputs immediately at reset values; no resp_valid after release; next grant goes to requester 0.
